// File: rtl/dport_axi.sv
// CPU data-port to single-beat AXI4 master bridge. Build option DPORT_AXI_POSTED_WR_EN
// acknowledges writes once AW and W have handshaken, then drains B without reporting it.
module dport_axi #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic        mem_d_cacheable_i,
    input  logic [10:0] mem_d_req_tag_i,
    input  logic        mem_d_invalidate_i,
    input  logic        mem_d_writeback_i,
    input  logic        mem_d_flush_i,
    output logic [31:0] mem_d_data_rd_o,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic        mem_d_error_o,
    output logic [10:0] mem_d_resp_tag_o,
    output logic        axi_awvalid_o,
    output logic [31:0] axi_awaddr_o,
    output logic [3:0]  axi_awid_o,
    output logic [7:0]  axi_awlen_o,
    output logic [1:0]  axi_awburst_o,
    input  logic        axi_awready_i,
    output logic        axi_wvalid_o,
    output logic [31:0] axi_wdata_o,
    output logic [3:0]  axi_wstrb_o,
    output logic        axi_wlast_o,
    input  logic        axi_wready_i,
    input  logic        axi_bvalid_i,
    input  logic [1:0]  axi_bresp_i,
    input  logic [3:0]  axi_bid_i,
    output logic        axi_bready_o,
    output logic        axi_arvalid_o,
    output logic [31:0] axi_araddr_o,
    output logic [3:0]  axi_arid_o,
    output logic [7:0]  axi_arlen_o,
    output logic [1:0]  axi_arburst_o,
    input  logic        axi_arready_i,
    input  logic        axi_rvalid_i,
    input  logic [31:0] axi_rdata_i,
    input  logic [1:0]  axi_rresp_i,
    input  logic [3:0]  axi_rid_i,
    input  logic        axi_rlast_i,
    output logic        axi_rready_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_RESP = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        MAINT   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_awvalid;
    logic        r_wvalid;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_strb;
    logic [10:0] r_tag;
    logic [31:0] r_rdata;
    logic        r_ack;
    logic        r_error;

    logic        w_req;
    logic        w_take;
    logic        w_aw_done;
    logic        w_w_done;
    logic        w_accept;
    logic        w_arvalid;
    logic        w_rready;
    logic        w_bready;
    logic        w_unused;

    assign w_req     = mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i |
                       mem_d_invalidate_i | mem_d_writeback_i;
    assign w_take    = (r_state == IDLE) && w_req;
    assign w_aw_done = !r_awvalid || axi_awready_i;
    assign w_w_done  = !r_wvalid || axi_wready_i;
    assign w_unused  = ^{mem_d_cacheable_i, axi_bid_i, axi_rid_i, axi_rlast_i,
                         axi_bresp_i, r_addr[1:0]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        w_bready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = 1'b1;
                if (w_req) begin
                    if (|mem_d_wr_i)     w_next = WR_REQ;
                    else if (mem_d_rd_i) w_next = RD_REQ;
                    else                 w_next = MAINT;
                end
            end
            RD_REQ: begin
                w_arvalid = 1'b1;
                if (axi_arready_i) w_next = RD_RESP;
            end
            RD_RESP: begin
                w_rready = 1'b1;
                if (axi_rvalid_i) w_next = IDLE;
            end
            WR_REQ: begin
                if (w_aw_done && w_w_done) w_next = WR_RESP;
            end
            WR_RESP: begin
                w_bready = 1'b1;
                if (axi_bvalid_i) w_next = IDLE;
            end
            MAINT: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // AW and W valids are tracked separately so each can retire on its own handshake
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
        end else if (w_take && (|mem_d_wr_i)) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
        end else if (r_state == WR_REQ) begin
            if (axi_awready_i) r_awvalid <= 1'b0;
            if (axi_wready_i)  r_wvalid  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_take) begin
            r_addr  <= mem_d_addr_i;
            r_wdata <= mem_d_data_wr_i;
            r_strb  <= mem_d_wr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_tag   <= 11'd0;
            r_rdata <= 32'd0;
            r_ack   <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (w_take) begin
                r_tag <= mem_d_req_tag_i;
                if (!(|mem_d_wr_i) && !mem_d_rd_i) begin
                    r_ack   <= 1'b1;
                    r_error <= 1'b0;
                end
            end
            if ((r_state == RD_RESP) && axi_rvalid_i) begin
                r_ack   <= 1'b1;
                r_error <= (axi_rresp_i != 2'b00);
                r_rdata <= axi_rdata_i;
            end
`ifdef DPORT_AXI_POSTED_WR_EN
            if ((r_state == WR_REQ) && w_aw_done && w_w_done) begin
                r_ack   <= 1'b1;
                r_error <= 1'b0;
            end
`else
            if ((r_state == WR_RESP) && axi_bvalid_i) begin
                r_ack   <= 1'b1;
                r_error <= (axi_bresp_i != 2'b00);
            end
`endif
        end
    end

    assign mem_d_accept_o   = w_accept;
    assign mem_d_ack_o      = r_ack;
    assign mem_d_error_o    = r_error;
    assign mem_d_resp_tag_o = r_tag;
    assign mem_d_data_rd_o  = r_rdata;

    assign axi_awvalid_o  = r_awvalid;
    assign axi_awaddr_o   = {r_addr[31:2], 2'b00};
    assign axi_awid_o     = AXI_ID;
    assign axi_awlen_o    = 8'd0;
    assign axi_awburst_o  = 2'b01;
    assign axi_wvalid_o   = r_wvalid;
    assign axi_wdata_o    = r_wdata;
    assign axi_wstrb_o    = r_strb;
    assign axi_wlast_o    = 1'b1;
    assign axi_bready_o   = w_bready;
    assign axi_arvalid_o  = w_arvalid;
    assign axi_araddr_o   = {r_addr[31:2], 2'b00};
    assign axi_arid_o     = AXI_ID;
    assign axi_arlen_o    = 8'd0;
    assign axi_arburst_o  = 2'b01;
    assign axi_rready_o   = w_rready;

endmodule

// File: tb/tb_dport_axi.sv
// Directed and randomized bench for dport_axi; the bench plays the AXI slave and
// derives every expected value from the request it issued.
module tb_dport_axi;

`ifdef DPORT_AXI_POSTED_WR_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif
    localparam logic [3:0] ID = 4'hA;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] mem_d_addr_i = '0;
    logic [31:0] mem_d_data_wr_i = '0;
    logic        mem_d_rd_i = 1'b0;
    logic [3:0]  mem_d_wr_i = '0;
    logic        mem_d_cacheable_i = 1'b0;
    logic [10:0] mem_d_req_tag_i = '0;
    logic        mem_d_invalidate_i = 1'b0;
    logic        mem_d_writeback_i = 1'b0;
    logic        mem_d_flush_i = 1'b0;
    logic [31:0] mem_d_data_rd_o;
    logic        mem_d_accept_o;
    logic        mem_d_ack_o;
    logic        mem_d_error_o;
    logic [10:0] mem_d_resp_tag_o;
    logic        axi_awvalid_o;
    logic [31:0] axi_awaddr_o;
    logic [3:0]  axi_awid_o;
    logic [7:0]  axi_awlen_o;
    logic [1:0]  axi_awburst_o;
    logic        axi_awready_i = 1'b0;
    logic        axi_wvalid_o;
    logic [31:0] axi_wdata_o;
    logic [3:0]  axi_wstrb_o;
    logic        axi_wlast_o;
    logic        axi_wready_i = 1'b0;
    logic        axi_bvalid_i = 1'b0;
    logic [1:0]  axi_bresp_i = '0;
    logic [3:0]  axi_bid_i = '0;
    logic        axi_bready_o;
    logic        axi_arvalid_o;
    logic [31:0] axi_araddr_o;
    logic [3:0]  axi_arid_o;
    logic [7:0]  axi_arlen_o;
    logic [1:0]  axi_arburst_o;
    logic        axi_arready_i = 1'b0;
    logic        axi_rvalid_i = 1'b0;
    logic [31:0] axi_rdata_i = '0;
    logic [1:0]  axi_rresp_i = '0;
    logic [3:0]  axi_rid_i = '0;
    logic        axi_rlast_i = 1'b0;
    logic        axi_rready_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata = '0;

    always #5 clk_i = ~clk_i;

    dport_axi #(.AXI_ID(ID)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
        .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i),
        .mem_d_cacheable_i(mem_d_cacheable_i), .mem_d_req_tag_i(mem_d_req_tag_i),
        .mem_d_invalidate_i(mem_d_invalidate_i), .mem_d_writeback_i(mem_d_writeback_i),
        .mem_d_flush_i(mem_d_flush_i), .mem_d_data_rd_o(mem_d_data_rd_o),
        .mem_d_accept_o(mem_d_accept_o), .mem_d_ack_o(mem_d_ack_o),
        .mem_d_error_o(mem_d_error_o), .mem_d_resp_tag_o(mem_d_resp_tag_o),
        .axi_awvalid_o(axi_awvalid_o), .axi_awaddr_o(axi_awaddr_o),
        .axi_awid_o(axi_awid_o), .axi_awlen_o(axi_awlen_o),
        .axi_awburst_o(axi_awburst_o), .axi_awready_i(axi_awready_i),
        .axi_wvalid_o(axi_wvalid_o), .axi_wdata_o(axi_wdata_o),
        .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
        .axi_wready_i(axi_wready_i), .axi_bvalid_i(axi_bvalid_i),
        .axi_bresp_i(axi_bresp_i), .axi_bid_i(axi_bid_i),
        .axi_bready_o(axi_bready_o), .axi_arvalid_o(axi_arvalid_o),
        .axi_araddr_o(axi_araddr_o), .axi_arid_o(axi_arid_o),
        .axi_arlen_o(axi_arlen_o), .axi_arburst_o(axi_arburst_o),
        .axi_arready_i(axi_arready_i), .axi_rvalid_i(axi_rvalid_i),
        .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
        .axi_rid_i(axi_rid_i), .axi_rlast_i(axi_rlast_i),
        .axi_rready_o(axi_rready_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_req();
        mem_d_rd_i = 1'b0;
        mem_d_wr_i = 4'd0;
        mem_d_flush_i = 1'b0;
        mem_d_invalidate_i = 1'b0;
        mem_d_writeback_i = 1'b0;
        mem_d_addr_i = $urandom;
        mem_d_data_wr_i = $urandom;
        mem_d_req_tag_i = 11'($urandom);
    endtask

    // Called at a negedge with the bridge idle; returns at the negedge of the ack cycle.
    task automatic do_read(input logic [31:0] addr, input logic [10:0] tag,
                           input logic [31:0] rdata, input logic [1:0] rresp,
                           input int ar_dly, input int r_dly, input bit with_maint);
        chk("rd_accept", mem_d_accept_o, 1);
        mem_d_addr_i = addr;
        mem_d_rd_i = 1'b1;
        mem_d_flush_i = with_maint;
        mem_d_req_tag_i = tag;
        @(negedge clk_i);
        clr_req();
        chk("rd_ack_drop", mem_d_ack_o, 0);
        for (int c = 0; c <= ar_dly; c++) begin
            chk("arvalid", axi_arvalid_o, 1);
            chk("araddr", axi_araddr_o, {addr[31:2], 2'b00});
            chk("ar_static", {axi_arlen_o, axi_arburst_o, axi_arid_o}, {8'd0, 2'b01, ID});
            chk("rd_busy_accept", mem_d_accept_o, 0);
            chk("rd_no_aw", axi_awvalid_o, 0);
            axi_arready_i = (c == ar_dly);
            @(negedge clk_i);
        end
        axi_arready_i = 1'b0;
        for (int c = 0; c <= r_dly; c++) begin
            chk("rready", axi_rready_o, 1);
            chk("arvalid_drop", axi_arvalid_o, 0);
            chk("rd_early_ack", mem_d_ack_o, 0);
            axi_rvalid_i = (c == r_dly);
            axi_rdata_i = (c == r_dly) ? rdata : $urandom;
            axi_rresp_i = (c == r_dly) ? rresp : 2'($urandom);
            axi_rid_i = 4'($urandom);
            axi_rlast_i = 1'b1;
            @(negedge clk_i);
        end
        axi_rvalid_i = 1'b0;
        exp_rdata = rdata;
        chk("rd_ack", mem_d_ack_o, 1);
        chk("rd_tag", mem_d_resp_tag_o, tag);
        chk("rd_data", mem_d_data_rd_o, rdata);
        chk("rd_error", mem_d_error_o, rresp != 2'b00);
        chk("rd_ack_accept", mem_d_accept_o, 1);
        chk("rready_drop", axi_rready_o, 0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [10:0] tag,
                            input logic [1:0] bresp, input int aw_dly, input int w_dly,
                            input int b_dly, input bit also_rd);
        int mx;
        mx = (aw_dly > w_dly) ? aw_dly : w_dly;
        chk("wr_accept", mem_d_accept_o, 1);
        mem_d_addr_i = addr;
        mem_d_data_wr_i = data;
        mem_d_wr_i = strb;
        mem_d_rd_i = also_rd;
        mem_d_req_tag_i = tag;
        @(negedge clk_i);
        clr_req();
        for (int c = 0; c <= mx; c++) begin
            chk("awvalid", axi_awvalid_o, c <= aw_dly);
            chk("wvalid", axi_wvalid_o, c <= w_dly);
            if (c <= aw_dly) chk("awaddr", axi_awaddr_o, {addr[31:2], 2'b00});
            if (c <= w_dly) chk("wpayload", {axi_wdata_o, axi_wstrb_o, axi_wlast_o},
                                {data, strb, 1'b1});
            chk("wr_no_ar", axi_arvalid_o, 0);
            chk("wr_bready_early", axi_bready_o, 0);
            chk("wr_busy_accept", mem_d_accept_o, 0);
            chk("wr_early_ack", mem_d_ack_o, 0);
            axi_awready_i = (c == aw_dly);
            axi_wready_i = (c == w_dly);
            @(negedge clk_i);
        end
        axi_awready_i = 1'b0;
        axi_wready_i = 1'b0;
        if (POSTED) begin
            chk("posted_ack", mem_d_ack_o, 1);
            chk("posted_tag", mem_d_resp_tag_o, tag);
            chk("posted_err", mem_d_error_o, 0);
        end
        for (int c = 0; c <= b_dly; c++) begin
            chk("bready", axi_bready_o, 1);
            chk("wr_resp_accept", mem_d_accept_o, 0);
            chk("wr_valids_drop", {axi_awvalid_o, axi_wvalid_o}, 0);
            if (c > 0 || !POSTED) chk("wr_resp_ack", mem_d_ack_o, 0);
            axi_bvalid_i = (c == b_dly);
            axi_bresp_i = (c == b_dly) ? bresp : 2'($urandom);
            axi_bid_i = 4'($urandom);
            @(negedge clk_i);
        end
        axi_bvalid_i = 1'b0;
        chk("wr_done_accept", mem_d_accept_o, 1);
        chk("bready_drop", axi_bready_o, 0);
        chk("wr_keeps_rdata", mem_d_data_rd_o, exp_rdata);
        if (POSTED) begin
            chk("posted_no_b_ack", mem_d_ack_o, 0);
        end else begin
            chk("wr_ack", mem_d_ack_o, 1);
            chk("wr_tag", mem_d_resp_tag_o, tag);
            chk("wr_error", mem_d_error_o, bresp != 2'b00);
        end
    endtask

    task automatic do_maint(input int kind, input logic [10:0] tag);
        chk("mt_accept", mem_d_accept_o, 1);
        mem_d_flush_i = (kind == 0);
        mem_d_invalidate_i = (kind == 1);
        mem_d_writeback_i = (kind == 2);
        mem_d_req_tag_i = tag;
        mem_d_addr_i = $urandom;
        @(negedge clk_i);
        clr_req();
        chk("mt_ack", mem_d_ack_o, 1);
        chk("mt_tag", mem_d_resp_tag_o, tag);
        chk("mt_err", mem_d_error_o, 0);
        chk("mt_no_axi", {axi_arvalid_o, axi_awvalid_o, axi_wvalid_o}, 0);
        chk("mt_rdata", mem_d_data_rd_o, exp_rdata);
        @(negedge clk_i);
        chk("mt_ack_drop", mem_d_ack_o, 0);
        chk("mt_idle", mem_d_accept_o, 1);
    endtask

    initial begin
        rst_i = 1'b0;
        #1;
        chk("rst_valids", {axi_arvalid_o, axi_awvalid_o, axi_wvalid_o, axi_rready_o, axi_bready_o}, 0);
        chk("rst_ack_err", {mem_d_ack_o, mem_d_error_o}, 0);
        chk("rst_tag", mem_d_resp_tag_o, 0);
        chk("rst_rdata", mem_d_data_rd_o, 0);
        chk("rst_accept", mem_d_accept_o, 1);
        chk("rst_static", {axi_awlen_o, axi_awburst_o, axi_awid_o, axi_wlast_o},
            {8'd0, 2'b01, ID, 1'b1});
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        do_read(32'h1000_0006, 11'h155, 32'hCAFE_BABE, 2'b00, 0, 0, 1'b0);
        @(negedge clk_i);
        do_write(32'h2000_0000, 32'h1234_5678, 4'b0011, 11'h0AA, 2'b00, 3, 0, 1, 1'b0);
        if (!POSTED) @(negedge clk_i);
        do_read(32'h4000_0013, 11'h2F1, 32'h0BAD_F00D, 2'b10, 1, 2, 1'b0);
        do_read(32'h4000_0020, 11'h001, 32'h5555_AAAA, 2'b00, 0, 1, 1'b1);
        @(negedge clk_i);
        do_maint(0, 11'h007);
        do_write(32'h3000_0101, 32'hDEAD_BEEF, 4'b1111, 11'h3FF, 2'b10, 0, 2, 0, 1'b1);
        if (!POSTED) @(negedge clk_i);
        do_write(32'h3000_0200, 32'h0102_0304, 4'b1000, 11'h123, 2'b00, 1, 1, 5, 1'b0);
        if (!POSTED) @(negedge clk_i);

        for (int i = 0; i < 24; i++) begin
            int op;
            op = $urandom_range(0, 2);
            if (op == 0) begin
                do_read($urandom, 11'($urandom), $urandom, 2'($urandom),
                        $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
                @(negedge clk_i);
            end else if (op == 1) begin
                do_write($urandom, $urandom, 4'($urandom_range(1, 15)), 11'($urandom),
                         2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 4), 1'($urandom));
                if (!POSTED) @(negedge clk_i);
            end else begin
                do_maint($urandom_range(0, 2), 11'($urandom));
            end
        end

        chk("pre_rst_accept", mem_d_accept_o, 1);
        mem_d_addr_i = 32'h5000_0010;
        mem_d_rd_i = 1'b1;
        mem_d_req_tag_i = 11'h0C3;
        @(negedge clk_i);
        clr_req();
        for (int c = 0; c < 10; c++) begin
            chk("stall_arvalid", axi_arvalid_o, 1);
            chk("stall_araddr", axi_araddr_o, 32'h5000_0010);
            chk("stall_accept", mem_d_accept_o, 0);
            @(negedge clk_i);
        end
        rst_i = 1'b0;
        #1;
        chk("rst_arvalid_async", axi_arvalid_o, 0);
        chk("rst_no_ack", mem_d_ack_o, 0);
        axi_rvalid_i = 1'b1;
        @(negedge clk_i);
        chk("rst_hold_no_ack", mem_d_ack_o, 0);
        rst_i = 1'b1;
        axi_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_idle", {mem_d_accept_o, axi_arvalid_o, axi_rready_o, mem_d_ack_o}, 4'b1000);
        chk("post_rst_rdata", mem_d_data_rd_o, 0);
        exp_rdata = '0;
        do_read(32'h6000_0008, 11'h444, 32'h8765_4321, 2'b00, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
